apb_slv_mux: RTL and testbench
==============================

Name: apb_slv_mux

Overview:
- APB-side resource controller for the AHB-to-APB bridge.
- Decodes the bridge's `paddr` into one-hot slave selects and latches the selected slave for the whole transfer.
- Muxes each slave's `pready`/`pslverr`/`prdata` back to the bridge.
- Sequences each transfer through SETUP/ACCESS, terminating unmapped addresses and hung slaves with a clean error completion.

Parameters:
- NUM_SLV, 4, number of APB slaves (2..8).
- PADDR_WIDTH, 16, APB address width; must equal bridge `PADDR_WIDTH`.
- APB_DATA_WIDTH, 32, APB data width.
- IDX_LSB, 12, LSB of the slave index field in `paddr`; field width IDX_W = 3 bits, i.e. `paddr[IDX_LSB+2:IDX_LSB]`.
- TIMEOUT_CYC, 255, max ACCESS-phase wait cycles before forced error (1..1023).

Ports:
- hclk  in  1  system clock (shared with AHB side).
- hreset_n  in  1  asynchronous active-low reset.
- psel_in  in  1  bridge transfer active (high in SETUP and ACCESS).
- penable  in  1  bridge APB enable (ACCESS phase).
- paddr  in  PADDR_WIDTH  bridge APB address.
- psel_x  out  NUM_SLV  one-hot slave select.
- pready_x  in  NUM_SLV  per-slave ready.
- pslverr_x  in  NUM_SLV  per-slave error.
- prdata_x  in  NUM_SLV*APB_DATA_WIDTH  per-slave read data, slave i at bits [i*W +: W].
- pready  out  1  muxed ready to bridge.
- pslverr  out  1  muxed/forced error to bridge.
- prdata  out  APB_DATA_WIDTH  muxed read data to bridge.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset: async on `hreset_n` low.
  - State = IDLE, `sel_idx` = 0, `dec_err` = 0, `tmo_cnt` = 0.
  - All outputs 0: `psel_x` = 0, `pready` = 0, `pslverr` = 0, `prdata` = 0, `busy` = 0.
- Decode: `idx = paddr[IDX_LSB+2:IDX_LSB]`. `idx >= NUM_SLV` flags an unmapped address.
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - `psel_in` high with `penable` low: latch `sel_idx` = idx and `dec_err` = (idx >= NUM_SLV), then go to SETUP.
  - `psel_in` high with `penable` high in IDLE is a protocol violation: ignore it and stay in IDLE.
- `psel_x` generation:
  - `psel_x[i]` = `psel_in` & ~`dec_err_eff` & (`idx_eff` == i), where `idx_eff`/`dec_err_eff` are the live decode in IDLE and the latched values otherwise.
  - This gives zero-latency select in the setup cycle.
  - An unmapped address never asserts any `psel_x`.
- SETUP: lasts 1 cycle, then go to ACCESS. `pready` = 0.
- ACCESS, with `penable` high:
  - `dec_err`: `pready` = 1 and `pslverr` = 1 combinationally in the first ACCESS cycle, `prdata` = 0, then go to IDLE.
  - Otherwise: `pready` = `pready_x[sel_idx]`, `pslverr` = `pslverr_x[sel_idx]` & `pready`, `prdata` = `prdata_x[sel_idx]`.
  - On `pready` = 1, go to IDLE.
- Outside ACCESS: `pready` = 0, `pslverr` = 0, `prdata` = 0.
- `psel_in` dropping while in SETUP or ACCESS (bridge abort/reset): go to IDLE next cycle with no completion; `tmo_cnt` cleared.
- Back-to-back transfers:
  - The completion cycle in ACCESS moves to IDLE.
  - If `psel_in` is high with `penable` low in the next cycle, a new transfer starts normally.
  - At most one `psel_x` bit is ever high.
- Every transfer takes at least 2 cycles (SETUP + ACCESS). Wait states equal slave `pready` low cycles.
- `sel_idx` is never updated outside IDLE, so `paddr` changes mid-transfer are ignored.

Optional Feature:
- Macro APB_SLV_TIMEOUT_EN.
- Defined:
  - 10-bit `tmo_cnt` increments each ACCESS cycle with the selected `pready_x` low, and clears on entering ACCESS.
  - When `tmo_cnt` == TIMEOUT_CYC and `pready_x` is still low: force `pready` = 1, `pslverr` = 1, `prdata` = 0 for that cycle, drop `psel_x`, return to IDLE.
  - A slave `pready_x` arriving in that same cycle wins: normal completion, no forced error.
- Undefined: no counter logic; ACCESS waits indefinitely for `pready_x`.

Test Plan:
- Read `paddr` = 0x2004, slave 2 `pready_x` high immediately, `prdata_x[2]` = 0xA5A5_0002 -> `psel_x` = 4'b0100 for exactly 2 cycles, `prdata` = 0xA5A5_0002, `pslverr` = 0, transfer completes in 2 cycles.
- Write `paddr` = 0x1010, slave 1 inserts 3 wait states then `pready` with `pslverr_x[1]` = 1 -> `psel_x` = 4'b0010 for 5 cycles, `pready` high only in cycle 5 with `pslverr` = 1.
- `paddr` = 0x6000 (idx 6, NUM_SLV = 4) -> `psel_x` stays 0, `pready` = 1 and `pslverr` = 1 in the ACCESS cycle, `prdata` = 0.
- Back-to-back: slave 0 then slave 3 with no idle cycle -> `psel_x` goes 0001 -> 1000, never two bits high, both complete with `pslverr` = 0.
- APB_SLV_TIMEOUT_EN, TIMEOUT_CYC = 8, slave 1 `pready_x` held low -> forced `pready`/`pslverr` after 8 wait cycles, `busy` low next cycle. With the macro undefined, the same stimulus keeps `busy` high.
- `hreset_n` low mid-ACCESS on slave 2 -> `psel_x`, `pready`, `pslverr`, `busy` go 0 immediately (async). After release, a fresh read to slave 0 completes normally.

Source files
------------

// File: rtl/apb_slv_mux.sv
// APB slave decode, select latch and response mux for the AHB-to-APB bridge.
// Optional ACCESS-phase watchdog is built in when APB_SLV_TIMEOUT_EN is defined.
module apb_slv_mux #(
  parameter int unsigned NUM_SLV        = 4,
  parameter int unsigned PADDR_WIDTH    = 16,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned IDX_LSB        = 12,
  parameter int unsigned TIMEOUT_CYC    = 255
) (
  input  logic                              hclk,
  input  logic                              hreset_n,
  input  logic                              psel_in,
  input  logic                              penable,
  input  logic [PADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLV-1:0]                psel_x,
  input  logic [NUM_SLV-1:0]                pready_x,
  input  logic [NUM_SLV-1:0]                pslverr_x,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_x,
  output logic                              pready,
  output logic                              pslverr,
  output logic [APB_DATA_WIDTH-1:0]         prdata,
  output logic                              busy
);
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TMO_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                    state_q, state_d, phase;
  logic [IDX_W-1:0]          idx_live, sel_idx_q, idx_eff;
  logic                      dec_err_live, dec_err_q, dec_err_eff;
  logic                      rdy_sel, err_sel;
  logic [APB_DATA_WIDTH-1:0] rdata_sel;
  logic                      acc_en, tmo_hit;
  logic                      unused_paddr;

  assign idx_live     = paddr[IDX_LSB +: IDX_W];
  assign dec_err_live = 32'(idx_live) >= NUM_SLV;
  assign unused_paddr = ^paddr;

  // The bus SETUP cycle is served from IDLE by the live decode, so a transfer
  // needs only SETUP + one ACCESS cycle.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && psel_in && !penable) phase = SETUP;
  end

  assign acc_en = (state_q == ACCESS) && psel_in && penable;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= IDLE;
      sel_idx_q <= '0;
      dec_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (phase == SETUP) begin
        sel_idx_q <= idx_live;
        dec_err_q <= dec_err_live;
      end
    end
  end

  // Response of the latched slave
  always_comb begin
    rdy_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        rdy_sel   = pready_x[i];
        err_sel   = pslverr_x[i];
        rdata_sel = prdata_x[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

`ifdef APB_SLV_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ACCESS || !psel_in) begin
      tmo_cnt_q <= '0;
    end else if (acc_en && !dec_err_q && !rdy_sel) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // A slave ready arriving in the limit cycle still wins
  assign tmo_hit = acc_en && !dec_err_q && !rdy_sel &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_W'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (phase)
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (!psel_in || (penable && (dec_err_q || rdy_sel || tmo_hit))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_eff     = (state_q == IDLE) ? idx_live : sel_idx_q;
    dec_err_eff = (state_q == IDLE) ? dec_err_live : dec_err_q;
    psel_x      = '0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      psel_x[i] = hreset_n && psel_in && !dec_err_eff && !tmo_hit && (idx_eff == IDX_W'(i));
    end
    if (acc_en) begin
      if (dec_err_q || tmo_hit) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else begin
        pready  = rdy_sel;
        pslverr = err_sel & rdy_sel;
        prdata  = rdata_sel;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_apb_slv_mux.sv
// Scoreboard bench for apb_slv_mux: driver pushes model expectations, monitor pops on completion.
`timescale 1ns/1ps
module tb_apb_slv_mux;
  localparam int unsigned NUM_SLV = 4;
  localparam int unsigned PW      = 16;
  localparam int unsigned DW      = 32;
  localparam int unsigned TMO     = 8;

  logic                    hclk = 1'b0;
  logic                    hreset_n;
  logic                    psel_in, penable;
  logic [PW-1:0]           paddr;
  logic [NUM_SLV-1:0]      psel_x, pready_x, pslverr_x;
  logic [NUM_SLV*DW-1:0]   prdata_x;
  logic                    pready, pslverr, busy;
  logic [DW-1:0]           prdata;

  apb_slv_mux #(
    .NUM_SLV(NUM_SLV), .PADDR_WIDTH(PW), .APB_DATA_WIDTH(DW),
    .IDX_LSB(12), .TIMEOUT_CYC(TMO)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .psel_in(psel_in), .penable(penable),
    .paddr(paddr), .psel_x(psel_x), .pready_x(pready_x), .pslverr_x(pslverr_x),
    .prdata_x(prdata_x), .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .busy(busy)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [NUM_SLV-1:0] sel;
    logic               err;
    logic [DW-1:0]      data;
    int                 cycles;
    bit                 forced;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: outcome of one transfer from address, slave wait states and slave error
  function automatic exp_t model(input logic [PW-1:0] addr, input int w, input bit err,
                                 input logic [DW-1:0] data);
    exp_t e;
    int   idx;
    idx      = int'(addr[14:12]);
    e.sel    = '0;
    e.err    = 1'b1;
    e.data   = '0;
    e.cycles = 2;
    e.forced = 1'b0;
    if (idx < int'(NUM_SLV)) begin
      e.sel = NUM_SLV'(1) << idx;
`ifdef APB_SLV_TIMEOUT_EN
      if (w > int'(TMO)) begin
        e.cycles = 2 + int'(TMO);
        e.forced = 1'b1;
        return e;
      end
`endif
      e.err    = err;
      e.data   = data;
      e.cycles = 2 + w;
    end
    return e;
  endfunction

  // Monitor: per-cycle select check and completion scoreboard
  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge hclk);
      if (!psel_in) begin
        cyc = 0;
        check("psel_x_idle", 64'(psel_x), 64'(0));
        check("pready_idle", 64'(pready), 64'(0));
      end else begin
        if (!penable) cyc = 1;
        else cyc++;
        if (exp_q.size() == 0) begin
          if (pready) check("unexpected_pready", 64'(pready), 64'(0));
        end else begin
          e = exp_q[0];
          check("psel_x", 64'(psel_x),
                64'((e.forced && cyc == e.cycles) ? NUM_SLV'(0) : e.sel));
          if (!penable) begin
            check("pready_setup", 64'(pready), 64'(0));
          end else if (pready) begin
            void'(exp_q.pop_front());
            check("cycles", 64'(cyc), 64'(e.cycles));
            check("pslverr", 64'(pslverr), 64'(e.err));
            check("prdata", 64'(prdata), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    psel_in   = 1'b0;
    penable   = 1'b0;
    pready_x  = '0;
    pslverr_x = '0;
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Bridge + slave driver; returns one cycle after completion, ready for back-to-back
  task automatic xfer(input logic [PW-1:0] addr, input int w, input bit err,
                      input logic [DW-1:0] data);
    int                 idx;
    int                 k;
    bit                 done;
    logic [NUM_SLV-1:0] oh;
    idx  = int'(addr[14:12]);
    oh   = (idx < int'(NUM_SLV)) ? (NUM_SLV'(1) << idx) : NUM_SLV'(0);
    k    = 0;
    done = 1'b0;
    for (int i = 0; i < int'(NUM_SLV); i++) prdata_x[i*DW +: DW] = $urandom;
    if (idx < int'(NUM_SLV)) prdata_x[idx*DW +: DW] = data;
    exp_q.push_back(model(addr, w, err, data));
    psel_in   = 1'b1;
    penable   = 1'b0;
    paddr     = addr;
    pready_x  = NUM_SLV'($urandom) & ~oh;
    pslverr_x = NUM_SLV'($urandom);
    @(posedge hclk);
    #1;
    penable = 1'b1;
    paddr   = PW'($urandom);
    while (!done) begin
      pready_x  = (NUM_SLV'($urandom) & ~oh) | ((k >= w) ? oh : NUM_SLV'(0));
      pslverr_x = (NUM_SLV'($urandom) & ~oh) | (err ? oh : NUM_SLV'(0));
      @(negedge hclk);
      done = pready;
      @(posedge hclk);
      #1;
      k++;
      if (!done && k > 1100) begin
        check("xfer_hang", 64'(k), 64'(0));
        done = 1'b1;
      end
    end
    pready_x  = '0;
    pslverr_x = '0;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [PW-1:0] a;
    hreset_n  = 1'b0;
    psel_in   = 1'b1;
    penable   = 1'b0;
    paddr     = '0;
    pready_x  = '1;
    pslverr_x = '1;
    prdata_x  = '1;
    #12;
    check("rst_psel_x", 64'(psel_x), 64'(0));
    check("rst_pready", 64'(pready), 64'(0));
    check("rst_pslverr", 64'(pslverr), 64'(0));
    check("rst_prdata", 64'(prdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    psel_in   = 1'b0;
    pready_x  = '0;
    pslverr_x = '0;
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    idle(2);

    xfer(16'h2004, 0, 1'b0, 32'hA5A5_0002);
    idle(1);
    xfer(16'h1010, 3, 1'b1, 32'h1234_5678);
    idle(1);
    xfer(16'h6000, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    xfer(16'h0000, 1, 1'b0, 32'h0000_0A0A);
    xfer(16'h3000, 0, 1'b0, 32'h3333_0003);
    idle(2);

    // psel_in with penable in IDLE must be ignored
    psel_in  = 1'b1;
    penable  = 1'b1;
    paddr    = 16'h1000;
    pready_x = '1;
    @(posedge hclk);
    #1;
    check("viol_busy", 64'(busy), 64'(0));
    check("viol_pready", 64'(pready), 64'(0));
    idle(1);

`ifdef APB_SLV_TIMEOUT_EN
    xfer(16'h1000, int'(TMO), 1'b0, 32'h0BAD_F00D);
    idle(1);
    xfer(16'h1000, 1000, 1'b0, 32'h5555_AAAA);
    check("busy_after_timeout", 64'(busy), 64'(0));
    idle(1);
`else
    psel_in  = 1'b1;
    penable  = 1'b0;
    paddr    = 16'h1000;
    pready_x = '0;
    @(posedge hclk);
    #1;
    penable = 1'b1;
    repeat (20) @(posedge hclk);
    #1;
    check("hang_busy", 64'(busy), 64'(1));
    check("hang_psel_x", 64'(psel_x), 64'(4'b0010));
    check("hang_pready", 64'(pready), 64'(0));
    psel_in = 1'b0;
    penable = 1'b0;
    @(posedge hclk);
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    idle(1);
`endif

    // Async reset in the middle of an ACCESS wait on slave 2
    psel_in   = 1'b1;
    penable   = 1'b0;
    paddr     = 16'h2000;
    pready_x  = '0;
    pslverr_x = '1;
    @(posedge hclk);
    #1;
    penable = 1'b1;
    @(posedge hclk);
    #1;
    check("pre_rst_busy", 64'(busy), 64'(1));
    check("pre_rst_psel_x", 64'(psel_x), 64'(4'b0100));
    #2;
    hreset_n = 1'b0;
    #1;
    check("mid_rst_psel_x", 64'(psel_x), 64'(0));
    check("mid_rst_pready", 64'(pready), 64'(0));
    check("mid_rst_pslverr", 64'(pslverr), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    psel_in   = 1'b0;
    penable   = 1'b0;
    pslverr_x = '0;
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    idle(2);
    xfer(16'h0040, 1, 1'b0, 32'hC0DE_0000);
    idle(2);

    for (int t = 0; t < 40; t++) begin
      a = {1'b0, 3'($urandom), 12'($urandom)};
      xfer(a, int'($urandom_range(0, 6)), 1'($urandom), DW'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
